// File: rtl/data_mem_bridge.sv
// Bridge between the core data-memory port and a req/gnt/rvalid system bus.
// One bus transaction per access, core stalled until completion, watchdog abort and fault reporting.
module data_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_core_addr,
    input  logic [DATA_W-1:0]   i_core_wdata,
    input  logic [DATA_W/8-1:0] i_core_be,
    input  logic                i_core_rd_en,
    input  logic                i_core_wr_en,
    output logic                o_core_ready,
    output logic [DATA_W-1:0]   o_core_rdata,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    output logic [DATA_W/8-1:0] o_bus_be,
    input  logic                i_bus_gnt,
    input  logic                i_bus_rvalid,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    input  logic                i_bus_err,
    output logic                o_fault,
    output logic                o_fault_sticky
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                we_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                fault_q;
    logic                sticky_q;

    logic                core_req;
    logic                timeout;
    logic                latch_en;
    logic                done_en;
    logic                done_fault;
    logic [DATA_W-1:0]   done_data;

    assign core_req = i_core_rd_en | i_core_wr_en;
    // Counter holds the number of cycles already spent in flight; this is the last allowed one.
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        done_en    = 1'b0;
        done_fault = 1'b0;
        done_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (core_req) begin
                    latch_en = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (i_bus_gnt && we_q) begin
                    done_en    = 1'b1;
                    done_fault = i_bus_err;
                    state_d    = DONE;
                end else if (i_bus_gnt && i_bus_rvalid) begin
                    done_en    = 1'b1;
                    done_fault = i_bus_err;
                    done_data  = i_bus_err ? '0 : i_bus_rdata;
                    state_d    = DONE;
                end else if (timeout) begin
                    done_en    = 1'b1;
                    done_fault = 1'b1;
                    state_d    = DONE;
                end else if (i_bus_gnt) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (i_bus_rvalid) begin
                    done_en    = 1'b1;
                    done_fault = i_bus_err;
                    done_data  = i_bus_err ? '0 : i_bus_rdata;
                    state_d    = DONE;
                end else if (timeout) begin
                    done_en    = 1'b1;
                    done_fault = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the latched request registers are reset too, so the bus outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= {i_core_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= i_core_wdata;
            be_q    <= i_core_be;
            we_q    <= i_core_wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (latch_en) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT_RSP) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Completion bookkeeping: stores and faults leave zero in the read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (done_en) begin
            rdata_q  <= done_data;
            fault_q  <= done_fault;
            sticky_q <= sticky_q | done_fault;
        end
    end

    assign o_core_ready   = ((state_q == IDLE) && !core_req) || (state_q == DONE);
    assign o_core_rdata   = rdata_q;
    assign o_bus_req      = (state_q == REQ);
    assign o_bus_we       = we_q;
    assign o_bus_addr     = addr_q;
    assign o_bus_wdata    = wdata_q;
    assign o_bus_be       = be_q;
    assign o_fault        = (state_q == DONE) && fault_q;
    assign o_fault_sticky = sticky_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: transaction-level model compared every cycle,
// plus literal expectations for the headline scenarios.
module tb_data_mem_bridge;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_core_addr;
    logic [31:0] i_core_wdata;
    logic [3:0]  i_core_be;
    logic        i_core_rd_en;
    logic        i_core_wr_en;
    logic        o_core_ready;
    logic [31:0] o_core_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;
    logic        o_fault;
    logic        o_fault_sticky;

    data_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata), .i_core_be(i_core_be),
        .i_core_rd_en(i_core_rd_en), .i_core_wr_en(i_core_wr_en),
        .o_core_ready(o_core_ready), .o_core_rdata(o_core_rdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .i_bus_err(i_bus_err), .o_fault(o_fault), .o_fault_sticky(o_fault_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int grant_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an access is either outstanding (with its age and grant status) or done.
    logic        m_busy, m_granted, m_done, m_fault, m_sticky, m_we;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_age;

    always @(posedge clk or negedge rst_n) begin
        logic        fin, f;
        logic [31:0] d;
        if (!rst_n) begin
            m_busy <= 0; m_granted <= 0; m_done <= 0; m_fault <= 0; m_sticky <= 0;
            m_we <= 0; m_rdata <= 0; m_addr <= 0; m_wdata <= 0; m_be <= 0; m_age <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_busy) begin
            if (i_core_rd_en || i_core_wr_en) begin
                m_busy <= 1; m_granted <= 0; m_age <= 0;
                m_we <= i_core_wr_en;
                m_addr <= i_core_addr & 32'hFFFF_FFFC;
                m_wdata <= i_core_wdata;
                m_be <= i_core_be;
            end
        end else begin
            fin = 0; f = 0; d = 0;
            if (!m_granted && i_bus_gnt && m_we) begin
                fin = 1; f = i_bus_err;
            end else if ((i_bus_rvalid && m_granted) || (i_bus_rvalid && i_bus_gnt && !m_granted)) begin
                fin = 1; f = i_bus_err; d = i_bus_err ? 0 : i_bus_rdata;
            end else if (m_age + 1 == TO) begin
                fin = 1; f = 1;
            end
            m_age <= m_age + 1;
            if (fin) begin
                m_busy <= 0; m_done <= 1; m_fault <= f; m_sticky <= m_sticky | f; m_rdata <= d;
            end else if (i_bus_gnt) begin
                m_granted <= 1;
            end
        end
    end

    // Per-cycle comparison, sampled after inputs settle and before the next rising edge.
    always @(negedge clk) begin
        #3;
        cyc_n++;
        check("ready", o_core_ready, m_done | (!m_busy & !(i_core_rd_en | i_core_wr_en)));
        check("bus_req", o_bus_req, m_busy & !m_granted);
        check("rdata", o_core_rdata, m_rdata);
        check("fault", o_fault, m_done & m_fault);
        check("sticky", o_fault_sticky, m_sticky);
        if (m_busy && !m_granted) begin
            check("bus_addr", o_bus_addr, m_addr);
            check("bus_we", o_bus_we, m_we);
            check("bus_wdata", o_bus_wdata, m_wdata);
            check("bus_be", o_bus_be, m_be);
        end
        if (o_bus_req && i_bus_gnt) grant_cyc.push_back(cyc_n);
    end

    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic g, input logic rv, input logic [31:0] rdt,
                       input logic e);
        @(negedge clk);
        i_core_rd_en = rd; i_core_wr_en = wr; i_core_addr = a; i_core_wdata = wd; i_core_be = be;
        i_bus_gnt = g; i_bus_rvalid = rv; i_bus_rdata = rdt; i_bus_err = e;
        #3;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        i_core_rd_en = 0; i_core_wr_en = 0; i_core_addr = 0; i_core_wdata = 0; i_core_be = 0;
        i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = 0; i_bus_err = 0;
        #2;
        check("rst_ready", o_core_ready, 1);
        check("rst_req", o_bus_req, 0);
        check("rst_rdata", o_core_rdata, 0);
        check("rst_sticky", o_fault_sticky, 0);
        check("rst_fault", o_fault, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Load 0x100, gnt on cycle 1, rvalid on cycle 3.
        cyc(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0);
        check("ld_stall", o_core_ready, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("ld_req", o_bus_req, 1);
        check("ld_addr", o_bus_addr, 32'h100);
        idle();
        check("ld_wait", o_core_ready, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        check("ld_wait2", o_core_ready, 0);
        idle();
        check("ld_done", o_core_ready, 1);
        check("ld_data", o_core_rdata, 32'hDEADBEEF);
        idle();

        // Store 0xAB, be=0001, addr 0x203; gnt on the 4th request cycle.
        cyc(0, 1, 32'h203, 32'h0000_00AB, 4'b0001, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, (i == 3), 0, 0, 0);
            check("st_req", o_bus_req, 1);
            check("st_addr", o_bus_addr, 32'h200);
            check("st_wdata", o_bus_wdata, 32'hAB);
            check("st_be", o_bus_be, 4'b0001);
        end
        idle();
        check("st_done", o_core_ready, 1);
        check("st_rdata0", o_core_rdata, 0);
        idle();

        // Load with gnt and rvalid together.
        cyc(1, 0, 32'h44, 0, 4'hF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h1234_5678, 0);
        idle();
        check("fast_done", o_core_ready, 1);
        check("fast_data", o_core_rdata, 32'h1234_5678);
        idle();

        // Load that is never answered: abort after TO cycles in flight.
        cyc(1, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0);
        repeat (TO) idle();
        idle();
        check("to_done", o_core_ready, 1);
        check("to_fault", o_fault, 1);
        check("to_rdata", o_core_rdata, 0);
        check("to_sticky", o_fault_sticky, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA, 0);
        check("late_fault", o_fault, 0);
        check("late_rdata", o_core_rdata, 0);
        check("late_sticky", o_fault_sticky, 1);

        // Read error, then reset during REQ.
        cyc(1, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D, 1);
        idle();
        check("err_fault", o_fault, 1);
        check("err_rdata", o_core_rdata, 0);
        idle();
        cyc(1, 0, 32'h500, 0, 4'hF, 0, 0, 0, 0);
        idle();
        check("pre_rst_req", o_bus_req, 1);
        rst_n = 0;
        #1;
        check("async_req", o_bus_req, 0);
        check("async_sticky", o_fault_sticky, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle();

        // Two consecutive stores.
        grant_cyc.delete();
        cyc(0, 1, 32'h600, 32'h11, 4'hF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        cyc(0, 1, 32'h604, 32'h22, 4'b0011, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        check("bb_count", grant_cyc.size(), 2);
        if (grant_cyc.size() == 2) check("bb_gap", grant_cyc[1] - grant_cyc[0], 3);

        // Load and store together: store wins; write error sampled with gnt.
        cyc(1, 1, 32'h700, 32'h77, 4'hF, 0, 0, 0, 0);
        idle();
        check("both_we", o_bus_we, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
        idle();
        check("werr_fault", o_fault, 1);
        check("werr_sticky", o_fault_sticky, 1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
